// File: rtl/traceback_sequencer.sv
// Traceback job sequencer: starts the traceback unit, stacks emitted (r,q) pairs in a LIFO,
// then streams them out top-left first over a valid/ready channel.
module traceback_sequencer #(
    parameter int unsigned L      = 8,
    parameter int unsigned B      = 4,
    parameter int unsigned TO_LIM = 2*L+4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_valid,
    output logic                        job_ready,
    output logic                        start_traceback,
    input  logic [2:0]                  tb_out_r,
    input  logic [2:0]                  tb_out_q,
    input  logic                        tb_finish,
    output logic                        tbmem_release,
    output logic                        aln_valid,
    input  logic                        aln_ready,
    output logic [2:0]                  aln_r,
    output logic [2:0]                  aln_q,
    output logic                        aln_last,
    output logic [$clog2(2*L):0]        aln_len,
    output logic                        job_done,
    output logic                        job_err
);
    localparam int unsigned DEPTH = 2*L;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned WW    = $clog2(TO_LIM + 1);
    localparam logic [PW-1:0] FULL    = PW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TO_LIM - 1);

    if (B < 1) begin : g_bad_b
        $error("traceback_sequencer: B must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] wd_q;
    logic [5:0]    lifo_q [DEPTH];
    logic          push, overflow, push_ok;
    logic [5:0]    top_pair, next_pair;

    always_comb begin
        push      = (state_q == COLLECT) && (tb_out_r != 3'b111);
        overflow  = push && (ptr_q == FULL);
        push_ok   = push && !overflow;
        ptr_d     = ptr_q + PW'(push_ok);
        // The pair pushed on the finishing edge is the new top, so forward it around the LIFO.
        top_pair  = push_ok ? {tb_out_r, tb_out_q} : lifo_q[AW'(ptr_q - PW'(1))];
        next_pair = lifo_q[AW'(ptr_q - PW'(2))];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            lifo_q[ptr_q[AW-1:0]] <= {tb_out_r, tb_out_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            wd_q            <= '0;
            job_ready       <= 1'b1;
            start_traceback <= 1'b0;
            tbmem_release   <= 1'b0;
            aln_valid       <= 1'b0;
            aln_r           <= 3'b111;
            aln_q           <= 3'b111;
            aln_last        <= 1'b0;
            aln_len         <= '0;
            job_done        <= 1'b0;
            job_err         <= 1'b0;
        end else begin
            tbmem_release <= 1'b0;
            job_done      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        state_q         <= COLLECT;
                        job_ready       <= 1'b0;
                        start_traceback <= 1'b1;
                        ptr_q           <= '0;
                        aln_len         <= '0;
                        job_err         <= 1'b0;
                        wd_q            <= '0;
                    end
                end
                COLLECT: begin
                    wd_q    <= wd_q + WW'(1);
                    ptr_q   <= ptr_d;
                    aln_len <= ptr_d;
                    if (overflow || (!tb_finish && wd_q == WD_LAST)) begin
                        start_traceback <= 1'b0;
                        tbmem_release   <= 1'b1;
                        job_err         <= 1'b1;
                        job_done        <= 1'b1;
                        state_q         <= DONE;
                    end else if (tb_finish) begin
                        start_traceback <= 1'b0;
                        tbmem_release   <= 1'b1;
                        if (ptr_d == '0) begin
                            job_done <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            aln_valid        <= 1'b1;
                            {aln_r, aln_q}   <= top_pair;
                            aln_last         <= (ptr_d == PW'(1));
                            state_q          <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (aln_ready) begin
                        ptr_q <= ptr_q - PW'(1);
                        if (ptr_q == PW'(1)) begin
                            aln_valid <= 1'b0;
                            aln_last  <= 1'b0;
                            aln_r     <= 3'b111;
                            aln_q     <= 3'b111;
                            job_done  <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            {aln_r, aln_q} <= next_pair;
                            aln_last       <= (ptr_q == PW'(2));
                        end
                    end
                end
                DONE: begin
                    job_ready <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_sequencer.sv
// Directed bench for traceback_sequencer: drives a traceback-unit model and scoreboards the
// drained alignment against the captured pairs in reverse order.
module tb_traceback_sequencer;
    localparam int L  = 8;
    localparam int TO = 2*L+4;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       job_valid = 1'b0, aln_ready = 1'b0, tb_finish = 1'b0;
    logic [2:0] tb_out_r = 3'b111, tb_out_q = 3'b111;
    logic       job_ready, start_traceback, tbmem_release, aln_valid, aln_last, job_done, job_err;
    logic [2:0] aln_r, aln_q;
    logic [4:0] aln_len;

    int vectors = 0, miscompares = 0;
    int rel_cnt, done_cnt, val_cnt, st_cnt, acc_cnt;
    logic last_err, prev_start;
    logic [6:0] expq[$];
    logic [2:0] pr[32], pq[32];

    traceback_sequencer #(.L(L), .B(4), .TO_LIM(TO)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .start_traceback(start_traceback), .tb_out_r(tb_out_r), .tb_out_q(tb_out_q),
        .tb_finish(tb_finish), .tbmem_release(tbmem_release), .aln_valid(aln_valid),
        .aln_ready(aln_ready), .aln_r(aln_r), .aln_q(aln_q), .aln_last(aln_last),
        .aln_len(aln_len), .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tbmem_release) rel_cnt++;
        if (job_done) begin done_cnt++; last_err = job_err; end
        if (aln_valid) val_cnt++;
        if (start_traceback) st_cnt++;
        if (start_traceback && !prev_start) acc_cnt++;
        prev_start = start_traceback;
    endtask

    task automatic clear_counts();
        rel_cnt = 0; done_cnt = 0; val_cnt = 0; st_cnt = 0; acc_cnt = 0;
        last_err = 1'b0; prev_start = start_traceback;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ":job_ready"}, 32'(job_ready), 1);
        check({tag, ":start"}, 32'(start_traceback), 0);
        check({tag, ":release"}, 32'(tbmem_release), 0);
        check({tag, ":aln_valid"}, 32'(aln_valid), 0);
        check({tag, ":aln_r"}, 32'(aln_r), 7);
        check({tag, ":aln_q"}, 32'(aln_q), 7);
        check({tag, ":aln_last"}, 32'(aln_last), 0);
        check({tag, ":aln_len"}, 32'(aln_len), 0);
        check({tag, ":job_done"}, 32'(job_done), 0);
        check({tag, ":job_err"}, 32'(job_err), 0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        job_valid = 1'b0; tb_finish = 1'b0; tb_out_r = 3'b111; tb_out_q = 3'b111; aln_ready = 1'b0;
        #1 check_reset(tag);
        expq.delete();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic fill_diag(input int n);
        for (int i = 0; i < n; i++) begin
            pr[i] = 3'(i % 4);
            pq[i] = 3'(i % 4);
        end
    endtask

    task automatic fill_gapped(input int n);
        for (int i = 0; i < n; i++) begin
            pr[i] = (i % 3 == 1) ? 3'b100 : 3'(i % 4);
            pq[i] = (i % 3 == 2) ? 3'b100 : 3'((i + 1) % 4);
        end
    endtask

    task automatic run_job(input string tag, input int n, input bit fin, input bit toggle,
                           input bit hold, input int exp_len, input bit exp_err);
        int k;
        clear_counts();
        expq.delete();
        k = 0;
        while (!job_ready && k < 50) begin cyc(); k++; end
        check({tag, ":ready"}, 32'(job_ready), 1);
        job_valid = 1'b1;
        cyc();
        if (!hold) job_valid = 1'b0;
        check({tag, ":start"}, 32'(start_traceback), 1);
        check({tag, ":busy"}, 32'(job_ready), 0);
        cyc();
        for (int i = 0; i < n; i++) begin
            tb_out_r  = pr[i];
            tb_out_q  = pq[i];
            tb_finish = fin && (i == n - 1);
            if (!exp_err) expq.push_front({pr[i], pq[i], i == 0});
            cyc();
            if (!start_traceback) break;
        end
        tb_out_r = 3'b111; tb_out_q = 3'b111; tb_finish = 1'b0;
        k = 0;
        while (start_traceback && k < 100) begin cyc(); k++; end
        check({tag, ":stop"}, 32'(start_traceback), 0);
        k = 0;
        while (expq.size() > 0 && k < 200) begin
            aln_ready = toggle ? (k % 2 == 0) : 1'b1;
            check({tag, ":valid"}, 32'(aln_valid), 1);
            if (!aln_valid) break;
            if (aln_ready) check({tag, ":beat"}, 32'({aln_r, aln_q, aln_last}), 32'(expq.pop_front()));
            else           check({tag, ":hold"}, 32'({aln_r, aln_q, aln_last}), 32'(expq[0]));
            cyc();
            k++;
        end
        aln_ready = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 50) begin cyc(); k++; end
        check({tag, ":done_cnt"}, done_cnt, 1);
        check({tag, ":err"}, 32'(last_err), 32'(exp_err));
        check({tag, ":release_cnt"}, rel_cnt, 1);
        check({tag, ":len"}, 32'(aln_len), exp_len);
        check({tag, ":accepts"}, acc_cnt, 1);
        if (exp_err) check({tag, ":no_valid"}, val_cnt, 0);
        cyc();
        check({tag, ":idle_ready"}, 32'(job_ready), 1);
        check({tag, ":done_off"}, 32'(job_done), 0);
        check({tag, ":valid_off"}, 32'(aln_valid), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset("por");
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        check_reset("idle");

        fill_diag(8);
        run_job("diag", 8, 1'b1, 1'b0, 1'b0, 8, 1'b0);

        fill_gapped(10);
        run_job("gapped", 10, 1'b1, 1'b1, 1'b0, 10, 1'b0);

        run_job("watchdog", 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("watchdog:start_cycles", st_cnt, TO);

        fill_diag(17);
        run_job("overflow", 17, 1'b0, 1'b0, 1'b0, 16, 1'b1);

        fill_diag(8);
        run_job("hold", 8, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        cyc();
        check("hold:reaccept", 32'(start_traceback), 1);

        // Mid-COLLECT reset: second accepted job is interrupted while pairs are arriving.
        clear_counts();
        job_valid = 1'b0;
        cyc();
        tb_out_r = 3'd1; tb_out_q = 3'd2;
        cyc(); cyc();
        do_reset("rst_collect");
        check("rst_collect:no_release", rel_cnt, 0);
        check("rst_collect:no_done", done_cnt, 0);

        // Mid-DRAIN reset: three pairs captured, consumer stalled.
        clear_counts();
        fill_diag(3);
        job_valid = 1'b1;
        cyc();
        job_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            tb_out_r = pr[i]; tb_out_q = pq[i]; tb_finish = (i == 2);
            cyc();
        end
        tb_out_r = 3'b111; tb_out_q = 3'b111; tb_finish = 1'b0;
        check("rst_drain:valid", 32'(aln_valid), 1);
        check("rst_drain:first_beat", 32'({aln_r, aln_q, aln_last}), 32'({pr[2], pq[2], 1'b0}));
        cyc();
        clear_counts();
        do_reset("rst_drain");
        check("rst_drain:no_done", done_cnt, 0);
        check("rst_drain:no_release", rel_cnt, 0);

        fill_gapped(5);
        run_job("after_rst", 5, 1'b1, 1'b1, 1'b0, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
